// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store sequencer driving a request/grant
// data-memory port. It builds byte enables and lane-aligned store data,
// sign- or zero-extends load results, and stalls the pipeline until the
// access completes.
// Optional feature macro: MISALIGN_SPLIT_EN. When it is defined, accesses
// that cross a word boundary are split into two beats. When it is not
// defined, an access whose offset is not a multiple of its size faults
// without touching memory.
//
// state | meaning
// IDLE  | waiting for a valid memory op; decode and capture on accept
// REQ0  | beat 0 request held on the port until granted
// RSP0  | waiting for beat 0 read data
// REQ1  | beat 1 request (next word), split accesses only
// RSP1  | waiting for beat 1 read data
// DONE  | one-cycle done/fault pulse, MEM stage advances on this edge
module mem_access_ctrl #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          op_valid,
  input  logic [4:0]    mem_op,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          stall,
  output logic          done,
  output logic          fault,
  output logic [31:0]   rdata,
  output logic          dm_req,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [3:0]    dm_be,
  output logic [31:0]   dm_wdata,
  input  logic          dm_gnt,
  input  logic          dm_rvalid,
  input  logic [31:0]   dm_rdata
);

  typedef enum logic [2:0] {IDLE, REQ0, RSP0, REQ1, RSP1, DONE} state_t;

  state_t      state;
  logic [2:0]  f3_q;
  logic        wr_q;
  logic [1:0]  off_q;

  logic        accept;
  logic [2:0]  f3_in;
  logic        wr_in;
  logic [1:0]  off_in;
  logic [3:0]  size_mask;
  logic        legal;
  logic        bad_in;
  logic [3:0]  be_lo;
  logic [31:0] rsp0_res;

  assign accept   = op_valid & mem_op[0];
  assign f3_in    = mem_op[4:2];
  assign wr_in    = mem_op[1];
  assign off_in   = addr[1:0];
  assign stall    = accept & (state != DONE);
  // Beat-0 read bytes [3:off] land in result bytes [3-off:0].
  assign rsp0_res = dm_rdata >> {off_q, 3'b000};

  // Access size as an unshifted byte mask: byte, half or word.
  always_comb begin
    case (f3_in[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  // Legal funct3 set; unsigned loads have no store counterpart.
  always_comb begin
    case (f3_in)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !wr_in;
      default:                legal = 1'b0;
    endcase
  end

`ifdef MISALIGN_SPLIT_EN
  logic [7:0]  mask_in;
  logic [3:0]  be_hi_in;
  logic        split_in;
  logic [2:0]  inv_off_in;
  logic [31:0] wdata_hi_in;
  logic        split_q;
  logic [3:0]  be_hi_q;
  logic [31:0] wdata_hi_q;
  logic [31:0] result_q;
  logic [2:0]  inv_off_q;
  logic [31:0] rsp1_res;

  // High nibble of the shifted mask is the beat-1 byte enable set.
  assign mask_in     = {4'b0000, size_mask} << off_in;
  assign be_lo       = mask_in[3:0];
  assign be_hi_in    = mask_in[7:4];
  assign split_in    = |be_hi_in;
  assign inv_off_in  = 3'd4 - {1'b0, off_in};
  assign wdata_hi_in = wdata >> {inv_off_in, 3'b000};
  assign inv_off_q   = 3'd4 - {1'b0, off_q};
  assign rsp1_res    = result_q | (dm_rdata << {inv_off_q, 3'b000});
  assign bad_in      = !legal;
`else
  assign be_lo  = size_mask << off_in;
  assign bad_in = !legal
                | ((f3_in[1:0] == 2'b01) & off_in[0])
                | ((f3_in[1:0] == 2'b10) & (|off_in));
`endif

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] r);
    logic [31:0] v;
    case (f3)
      3'b000:  v = {{24{r[7]}}, r[7:0]};
      3'b001:  v = {{16{r[15]}}, r[15:0]};
      3'b100:  v = {24'h000000, r[7:0]};
      3'b101:  v = {16'h0000, r[15:0]};
      default: v = r;
    endcase
    return v;
  endfunction

  // Sequencer FSM with registered port, pulse and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      f3_q     <= 3'b000;
      wr_q     <= 1'b0;
      off_q    <= 2'b00;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_be    <= 4'b0000;
      dm_wdata <= 32'h0;
      done     <= 1'b0;
      fault    <= 1'b0;
      rdata    <= 32'h0;
`ifdef MISALIGN_SPLIT_EN
      split_q    <= 1'b0;
      be_hi_q    <= 4'b0000;
      wdata_hi_q <= 32'h0;
      result_q   <= 32'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            f3_q  <= f3_in;
            wr_q  <= wr_in;
            off_q <= off_in;
`ifdef MISALIGN_SPLIT_EN
            split_q    <= split_in;
            be_hi_q    <= be_hi_in;
            wdata_hi_q <= wdata_hi_in;
`endif
            if (bad_in) begin
              state <= DONE;
              done  <= 1'b1;
              fault <= 1'b1;
            end else begin
              state    <= REQ0;
              dm_req   <= 1'b1;
              dm_we    <= wr_in;
              dm_addr  <= {addr[AW-1:2], 2'b00};
              dm_be    <= be_lo;
              dm_wdata <= wdata << {off_in, 3'b000};
            end
          end
        end
        REQ0: begin
          if (dm_gnt) begin
            if (!wr_q) begin
              state  <= RSP0;
              dm_req <= 1'b0;
            end
`ifdef MISALIGN_SPLIT_EN
            else if (split_q) begin
              state    <= REQ1;
              dm_addr  <= dm_addr + AW'(4);
              dm_be    <= be_hi_q;
              dm_wdata <= wdata_hi_q;
            end
`endif
            else begin
              state  <= DONE;
              done   <= 1'b1;
              dm_req <= 1'b0;
              dm_we  <= 1'b0;
            end
          end
        end
        RSP0: begin
          if (dm_rvalid) begin
`ifdef MISALIGN_SPLIT_EN
            if (split_q) begin
              result_q <= rsp0_res;
              state    <= REQ1;
              dm_req   <= 1'b1;
              dm_addr  <= dm_addr + AW'(4);
              dm_be    <= be_hi_q;
            end else
`endif
            begin
              state <= DONE;
              done  <= 1'b1;
              rdata <= extend(f3_q, rsp0_res);
            end
          end
        end
`ifdef MISALIGN_SPLIT_EN
        REQ1: begin
          if (dm_gnt) begin
            dm_req <= 1'b0;
            dm_we  <= 1'b0;
            if (!wr_q) begin
              state <= RSP1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RSP1: begin
          if (dm_rvalid) begin
            state <= DONE;
            done  <= 1'b1;
            rdata <= extend(f3_q, rsp1_res);
          end
        end
`endif
        DONE: begin
          done  <= 1'b0;
          fault <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a small grant/read-data responder.
module tb_mem_access_ctrl;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          op_valid;
  logic [4:0]    mem_op;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          stall, done, fault;
  logic [31:0]   rdata;
  logic          dm_req, dm_we;
  logic [AW-1:0] dm_addr;
  logic [3:0]    dm_be;
  logic [31:0]   dm_wdata;
  logic          dm_gnt, dm_rvalid;
  logic [31:0]   dm_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;

  int          beats, done_cyc, done_at;
  logic        req_seen, stable_ok, timed_out, got_fault;
  logic [31:0] got_rdata;
  logic [15:0] stall_hist;
  logic [31:0] b_addr  [2];
  logic [3:0]  b_be    [2];
  logic [31:0] b_wdata [2];
  logic        b_we    [2];

  mem_access_ctrl #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .mem_op(mem_op),
    .addr(addr), .wdata(wdata), .stall(stall), .done(done), .fault(fault),
    .rdata(rdata), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Drives one op from a negedge, grants after gwait wait cycles, returns
  // read data one cycle after each read grant, and records what it saw.
  // Ends at the negedge of the cycle following done.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input int gwait,
                        input logic [31:0] rd0, input logic [31:0] rd1);
    int cyc, wcnt, rv_beat;
    logic rv_pend;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_be;
    logic        h_we;
    beats = 0; req_seen = 0; stable_ok = 1; timed_out = 0; got_fault = 0;
    got_rdata = 32'h0; stall_hist = 16'h0; done_cyc = 0;
    h_addr = 0; h_wdata = 0; h_be = 0; h_we = 0;
    op_valid = 1'b1; mem_op = op; addr = a; wdata = wd;
    rv_pend = 0; rv_beat = 0; wcnt = 0; cyc = 1;
    while (1) begin
      #1;
      if (stall && cyc <= 16) stall_hist[cyc-1] = 1'b1;
      if (done) begin
        done_cyc = cyc; got_fault = fault; got_rdata = rdata; done_at = cyc_cnt;
        dm_gnt = 0; dm_rvalid = 0; dm_rdata = 0;
        break;
      end
      if (cyc >= 40) begin
        timed_out = 1; dm_gnt = 0; dm_rvalid = 0;
        break;
      end
      dm_rvalid = rv_pend;
      dm_rdata  = rv_pend ? ((rv_beat == 0) ? rd0 : rd1) : 32'h0;
      rv_pend   = 0;
      dm_gnt    = 0;
      if (dm_req) begin
        req_seen = 1;
        if (wcnt == 0) begin
          h_addr = dm_addr; h_be = dm_be; h_wdata = dm_wdata; h_we = dm_we;
        end else if (dm_addr !== h_addr || dm_be !== h_be ||
                     dm_wdata !== h_wdata || dm_we !== h_we) begin
          stable_ok = 0;
        end
        if (wcnt >= gwait) begin
          dm_gnt = 1;
          if (beats < 2) begin
            b_addr[beats] = dm_addr; b_be[beats] = dm_be;
            b_wdata[beats] = dm_wdata; b_we[beats] = dm_we;
          end
          if (!dm_we) begin rv_pend = 1; rv_beat = beats; end
          beats++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    op_valid = 1'b0; mem_op = 5'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0; op_valid = 0; mem_op = 0; addr = 0; wdata = 0;
    dm_gnt = 0; dm_rvalid = 0; dm_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++; if ({dm_req, dm_we, done, fault, stall} !== 5'b0) begin n_fail++; $display("FAIL reset_ctl got %b exp 00000", {dm_req, dm_we, done, fault, stall}); end
    n_tests++; if (dm_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", dm_addr); end
    n_tests++; if ({dm_be, dm_wdata} !== 36'h0) begin n_fail++; $display("FAIL reset_be_wdata got %h exp 0", {dm_be, dm_wdata}); end
    n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_sw_aligned();
    run_op(5'b01011, 32'h100, 32'hDEADBEEF, 0, 32'h0, 32'h0);
    n_tests++; if (done_cyc !== 3) begin n_fail++; $display("FAIL sw_latency got %0d exp 3", done_cyc); end
    n_tests++; if (beats !== 1) begin n_fail++; $display("FAIL sw_beats got %0d exp 1", beats); end
    n_tests++; if (b_addr[0] !== 32'h100) begin n_fail++; $display("FAIL sw_addr got %h exp 100", b_addr[0]); end
    n_tests++; if (b_be[0] !== 4'b1111) begin n_fail++; $display("FAIL sw_be got %b exp 1111", b_be[0]); end
    n_tests++; if (b_wdata[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata got %h exp deadbeef", b_wdata[0]); end
    n_tests++; if (b_we[0] !== 1'b1) begin n_fail++; $display("FAIL sw_we got %b exp 1", b_we[0]); end
    n_tests++; if (got_fault !== 1'b0) begin n_fail++; $display("FAIL sw_fault got %b exp 0", got_fault); end
    n_tests++; if (stall_hist !== 16'h0003) begin n_fail++; $display("FAIL sw_stall got %h exp 0003", stall_hist); end
  endtask

  task automatic test_lb_lbu();
    run_op(5'b00001, 32'h203, 32'h0, 0, 32'h80123456, 32'h0);
    n_tests++; if (b_addr[0] !== 32'h200 || b_be[0] !== 4'b1000 || b_we[0] !== 1'b0) begin n_fail++; $display("FAIL lb_beat got %h/%b/%b exp 200/1000/0", b_addr[0], b_be[0], b_we[0]); end
    n_tests++; if (done_cyc !== 4) begin n_fail++; $display("FAIL lb_latency got %0d exp 4", done_cyc); end
    n_tests++; if (got_rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_rdata got %h exp ffffff80", got_rdata); end
    run_op(5'b10001, 32'h203, 32'h0, 0, 32'h80123456, 32'h0);
    n_tests++; if (got_rdata !== 32'h00000080) begin n_fail++; $display("FAIL lbu_rdata got %h exp 00000080", got_rdata); end
    n_tests++; if (rdata !== 32'h00000080) begin n_fail++; $display("FAIL lbu_hold got %h exp 00000080", rdata); end
  endtask

  task automatic test_sh_delayed();
    run_op(5'b00111, 32'h12, 32'h0000A55A, 3, 32'h0, 32'h0);
    n_tests++; if (b_addr[0] !== 32'h10 || b_be[0] !== 4'b1100) begin n_fail++; $display("FAIL sh_beat got %h/%b exp 10/1100", b_addr[0], b_be[0]); end
    n_tests++; if (b_wdata[0] !== 32'hA55A0000) begin n_fail++; $display("FAIL sh_wdata got %h exp a55a0000", b_wdata[0]); end
    n_tests++; if (stable_ok !== 1'b1) begin n_fail++; $display("FAIL sh_stable got %b exp 1", stable_ok); end
    n_tests++; if (done_cyc !== 6) begin n_fail++; $display("FAIL sh_latency got %0d exp 6", done_cyc); end
    n_tests++; if (stall_hist !== 16'h001F) begin n_fail++; $display("FAIL sh_stall got %h exp 001f", stall_hist); end
  endtask

  task automatic test_misaligned();
`ifdef MISALIGN_SPLIT_EN
    run_op(5'b01001, 32'h1FE, 32'h0, 0, 32'hAAAABBBB, 32'hCCCCDDDD);
    n_tests++; if (beats !== 2) begin n_fail++; $display("FAIL lw_split_beats got %0d exp 2", beats); end
    n_tests++; if (b_addr[0] !== 32'h1FC || b_be[0] !== 4'b1100) begin n_fail++; $display("FAIL lw_split_b0 got %h/%b exp 1fc/1100", b_addr[0], b_be[0]); end
    n_tests++; if (b_addr[1] !== 32'h200 || b_be[1] !== 4'b0011) begin n_fail++; $display("FAIL lw_split_b1 got %h/%b exp 200/0011", b_addr[1], b_be[1]); end
    n_tests++; if (got_rdata !== 32'hDDDDAAAA) begin n_fail++; $display("FAIL lw_split_rdata got %h exp ddddaaaa", got_rdata); end
    n_tests++; if (done_cyc !== 6 || got_fault !== 1'b0) begin n_fail++; $display("FAIL lw_split_done got %0d/%b exp 6/0", done_cyc, got_fault); end
    run_op(5'b01011, 32'h103, 32'h11223344, 0, 32'h0, 32'h0);
    n_tests++; if (b_be[0] !== 4'b1000 || b_wdata[0] !== 32'h44000000) begin n_fail++; $display("FAIL sw_split_b0 got %b/%h exp 1000/44000000", b_be[0], b_wdata[0]); end
    n_tests++; if (b_addr[1] !== 32'h104 || b_be[1] !== 4'b0111 || b_wdata[1] !== 32'h00112233) begin n_fail++; $display("FAIL sw_split_b1 got %h/%b/%h exp 104/0111/00112233", b_addr[1], b_be[1], b_wdata[1]); end
    n_tests++; if (done_cyc !== 4) begin n_fail++; $display("FAIL sw_split_latency got %0d exp 4", done_cyc); end
    run_op(5'b00101, 32'h301, 32'h0, 0, 32'h12800134, 32'h0);
    n_tests++; if (beats !== 1 || b_be[0] !== 4'b0110) begin n_fail++; $display("FAIL lh_off1_beat got %0d/%b exp 1/0110", beats, b_be[0]); end
    n_tests++; if (got_rdata !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_off1_rdata got %h exp ffff8001", got_rdata); end
`else
    run_op(5'b01001, 32'h1FE, 32'h0, 0, 32'hAAAABBBB, 32'hCCCCDDDD);
    n_tests++; if (got_fault !== 1'b1 || done_cyc !== 2) begin n_fail++; $display("FAIL lw_mis_fault got %b/%0d exp 1/2", got_fault, done_cyc); end
    n_tests++; if (req_seen !== 1'b0) begin n_fail++; $display("FAIL lw_mis_noreq got %b exp 0", req_seen); end
    run_op(5'b01011, 32'h103, 32'h11223344, 0, 32'h0, 32'h0);
    n_tests++; if (got_fault !== 1'b1 || req_seen !== 1'b0) begin n_fail++; $display("FAIL sw_mis got %b/%b exp 1/0", got_fault, req_seen); end
    run_op(5'b00101, 32'h301, 32'h0, 0, 32'h12800134, 32'h0);
    n_tests++; if (got_fault !== 1'b1 || req_seen !== 1'b0) begin n_fail++; $display("FAIL lh_mis got %b/%b exp 1/0", got_fault, req_seen); end
    run_op(5'b00101, 32'h302, 32'h0, 0, 32'h80010000, 32'h0);
    n_tests++; if (got_fault !== 1'b0 || got_rdata !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_aligned got %b/%h exp 0/ffff8001", got_fault, got_rdata); end
`endif
  endtask

  task automatic test_illegal();
    run_op(5'b01101, 32'h0, 32'h0, 0, 32'h0, 32'h0);
    n_tests++; if (done_cyc !== 2 || got_fault !== 1'b1) begin n_fail++; $display("FAIL ill_load got %0d/%b exp 2/1", done_cyc, got_fault); end
    n_tests++; if (req_seen !== 1'b0) begin n_fail++; $display("FAIL ill_load_noreq got %b exp 0", req_seen); end
    n_tests++; if (stall_hist !== 16'h0001) begin n_fail++; $display("FAIL ill_stall got %h exp 0001", stall_hist); end
    run_op(5'b10011, 32'h40, 32'h5, 0, 32'h0, 32'h0);
    n_tests++; if (got_fault !== 1'b1 || req_seen !== 1'b0) begin n_fail++; $display("FAIL ill_store got %b/%b exp 1/0", got_fault, req_seen); end
  endtask

  task automatic test_reset_mid();
    op_valid = 1; mem_op = 5'b01001; addr = 32'h40; wdata = 0;
    dm_gnt = 0; dm_rvalid = 0;
    @(negedge clk); #1;
    dm_gnt = 1;
    @(negedge clk); #1;
    dm_gnt = 0;
    rst_n = 0; op_valid = 0; mem_op = 0;
    #1;
    n_tests++; if ({dm_req, dm_we, done, fault} !== 4'b0) begin n_fail++; $display("FAIL rstmid_ctl got %b exp 0000", {dm_req, dm_we, done, fault}); end
    n_tests++; if (dm_addr !== 32'h0 || dm_be !== 4'b0) begin n_fail++; $display("FAIL rstmid_port got %h/%b exp 0/0000", dm_addr, dm_be); end
    n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_rdata got %h exp 0", rdata); end
    @(negedge clk); rst_n = 1;
    @(negedge clk); dm_rvalid = 1; dm_rdata = 32'hFFFFFFFF;
    @(negedge clk); dm_rvalid = 0; dm_rdata = 0;
    #1;
    n_tests++; if (done !== 1'b0 || rdata !== 32'h0 || dm_req !== 1'b0) begin n_fail++; $display("FAIL stray_rvalid got %b/%h/%b exp 0/0/0", done, rdata, dm_req); end
    @(negedge clk);
    run_op(5'b10001, 32'h41, 32'h0, 0, 32'h00005A00, 32'h0);
    n_tests++; if (got_rdata !== 32'h0000005A || done_cyc !== 4) begin n_fail++; $display("FAIL after_reset_op got %h/%0d exp 0000005a/4", got_rdata, done_cyc); end
  endtask

  task automatic test_back_to_back();
    int d1;
    run_op(5'b01011, 32'h20, 32'h01020304, 0, 32'h0, 32'h0);
    d1 = done_at;
    run_op(5'b01001, 32'h24, 32'h0, 0, 32'h13579BDF, 32'h0);
    n_tests++; if (done_at - d1 !== 4) begin n_fail++; $display("FAIL b2b_gap got %0d exp 4", done_at - d1); end
    n_tests++; if (got_rdata !== 32'h13579BDF || b_addr[0] !== 32'h24) begin n_fail++; $display("FAIL b2b_load got %h/%h exp 13579bdf/24", got_rdata, b_addr[0]); end
  endtask

  initial begin
    test_reset();
    test_sw_aligned();
    test_lb_lbu();
    test_sh_delayed();
    test_misaligned();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end
endmodule
